tt_lut_eval: RTL

- Parametrised successor to the fixed 4-input gate-level truth-table cells.
- Evaluates any N_IN-input Boolean function from a 2^N_IN-bit truth table held in registers.
- The table is reloadable at run time over a serial config port, with an atomic commit.
- Evaluation runs through a ready/valid pipeline stage, so one block can replace a family of synthesised single-function netlists in the design flow.

---
 rtl/tt_lut_eval_if.sv | 30 +++
 rtl/tt_lut_eval.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tt_lut_eval_if.sv
// Handshake bundle for tt_lut_eval.
//   cfg_*  : serial truth-table load (valid/ready beats, abort, commit pulse)
//   in_*   : evaluation request (valid/ready, N_IN-bit table index)
//   out_*  : evaluation result (valid/ready, one function bit)
// master drives requests and config beats. slave is the evaluator.
interface tt_lut_eval_if #(
  parameter int unsigned N_IN = 4
) ();
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_bit;
  logic            cfg_abort;
  logic            cfg_done;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;

  modport master (
    output cfg_valid, cfg_bit, cfg_abort, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_bit
  );

  modport slave (
    input  cfg_valid, cfg_bit, cfg_abort, in_valid, in_data, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out_bit
  );
endinterface

// File: rtl/tt_lut_eval.sv
// Generic N_IN-input Boolean function evaluator driven by a 2^N_IN-bit truth table.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : tt_lut_eval_if slave modport
//                - config: cfg_valid/cfg_ready/cfg_bit, with cfg_abort and cfg_done
//                - eval:   in_valid/in_ready/in_data and out_valid/out_ready/out_bit
//   tt_active  : the committed truth table, for read-back
// The table loads LSB first into a shadow register. Once all TT_W bits are in, a single
// COMMIT cycle copies the shadow into the active table, so evaluation never sees a
// partially loaded table. Results come from a single output register with ready/valid flow.
module tt_lut_eval #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned TT_W    = 2 ** N_IN,
  parameter logic [15:0] TT_INIT = 16'h240F
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_lut_eval_if.slave    bus,
  output logic [TT_W-1:0] tt_active
);

  localparam int unsigned      CntW    = N_IN + 1;
  localparam logic [CntW-1:0]  CntFull = CntW'(TT_W);
  localparam logic [TT_W-1:0]  TtInitW = TT_W'(TT_INIT);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TT_W-1:0] shadow_q, shadow_d;
  logic [TT_W-1:0] active_q, active_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;

  logic cfg_ready;
  logic cfg_done;
  logic in_ready;
  logic accept;

  // Config side: ready depends on state only, so it never waits on cfg_valid.
  assign cfg_ready = (state_q != StCommit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cfg_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        // cfg_abort has nothing to discard here.
        if (bus.cfg_valid) begin
          shadow_d[0] = bus.cfg_bit;
          cnt_d       = CntW'(1);
          state_d     = (TT_W == 1) ? StCommit : StLoad;
        end
      end
      StLoad: begin
        if (bus.cfg_abort) begin
          // Abort beats a simultaneous beat. The active table is untouched.
          state_d  = StIdle;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (bus.cfg_valid) begin
          shadow_d[cnt_q[N_IN-1:0]] = bus.cfg_bit;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntFull) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        active_d = shadow_q;
        cnt_d    = '0;
        cfg_done = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Eval side: a free slot or a draining result lets a new request in.
  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    if (accept) begin
      // active_q still holds the old table during COMMIT. A request accepted then
      // sees the previous function.
      out_bit_d   = active_q[bus.in_data];
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= TtInitW;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_done  = cfg_done;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign tt_active     = active_q;

endmodule
